// File: rtl/moore_digit_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : moore_digit_sequencer
//  Description : Parametrised Moore ring-counter sequencer. Each state selects
//                an entry of a runtime-writable digit table, and that entry
//                drives the digit output. Supports up/down stepping, edge or
//                level manual stepping, a prescaled auto mode, hold, a
//                synchronous clear and a one-cycle wrap strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module moore_digit_sequencer #(
  parameter int NUM_STATES = 8,
  parameter int STATE_W    = 4,
  parameter int DIGIT_W    = 4,
  parameter int PRESCALE_W = 8,
  parameter int EDGE_STEP  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  step,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  wr_en,
  input  logic [STATE_W-1:0]    wr_addr,
  input  logic [DIGIT_W-1:0]    wr_data,
  output logic [STATE_W-1:0]    current_state,
  output logic [DIGIT_W-1:0]    digit,
  output logic                  wrap
);

  localparam logic [STATE_W-1:0] c_last_state  = STATE_W'(NUM_STATES - 1);
  localparam logic [1:0]         c_mode_manual = 2'b00;
  localparam logic [1:0]         c_mode_auto   = 2'b01;

  logic [STATE_W-1:0]    r_state;
  logic [STATE_W-1:0]    w_state_nxt;
  logic                  r_wrap;
  logic                  w_wrap_nxt;
  logic [PRESCALE_W-1:0] r_presc_cnt;
  logic [PRESCALE_W-1:0] w_presc_nxt;
  logic                  r_step_q;
  logic                  w_advance;
  logic [DIGIT_W-1:0]    r_table [NUM_STATES];
  logic [DIGIT_W-1:0]    w_digit;

  // Step history is tracked in every mode so entering manual never sees a stale edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= step;
    end
  end

  // Decide whether this cycle advances, and where the auto-mode prescaler goes next.
  always_comb begin
    w_advance   = 1'b0;
    w_presc_nxt = '0;
    case (mode)
      c_mode_manual: begin
        w_advance = (EDGE_STEP != 0) ? (step & ~r_step_q) : step;
      end
      c_mode_auto: begin
        // Exact-equal compare: a prescale lowered below the count waits for the counter to roll over.
        if (r_presc_cnt == prescale) begin
          w_advance   = 1'b1;
          w_presc_nxt = '0;
        end else begin
          w_presc_nxt = r_presc_cnt + PRESCALE_W'(1);
        end
      end
      default: begin
        // Hold and reserved: frozen state, prescaler parked at zero.
        w_advance   = 1'b0;
        w_presc_nxt = '0;
      end
    endcase
  end

  // Ring next-state and wrap strobe; clear overrides any advance.
  always_comb begin
    w_state_nxt = r_state;
    w_wrap_nxt  = 1'b0;
    if (r_state > c_last_state) begin
      // Unreachable index: recover to the start of the ring.
      w_state_nxt = '0;
    end else if (w_advance) begin
      if (!dir) begin
        if (r_state == c_last_state) begin
          w_state_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_state_nxt = r_state + STATE_W'(1);
        end
      end else begin
        if (r_state == '0) begin
          w_state_nxt = c_last_state;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_state_nxt = r_state - STATE_W'(1);
        end
      end
    end
    if (clear) begin
      w_state_nxt = '0;
      w_wrap_nxt  = 1'b0;
    end
  end

  // State, wrap and prescaler registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= '0;
      r_wrap      <= 1'b0;
      r_presc_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wrap      <= w_wrap_nxt;
      r_presc_cnt <= clear ? '0 : w_presc_nxt;
    end
  end

  // One register per table entry; addresses beyond the ring never match and are dropped.
  generate
    for (genvar i = 0; i < NUM_STATES; i++) begin : g_table
      // Entry i resets to i (truncated to digit width) and takes matching writes.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_table[i] <= DIGIT_W'(i);
        end else if (wr_en && (wr_addr == STATE_W'(i))) begin
          r_table[i] <= wr_data;
        end
      end
    end
  endgenerate

  // Moore output: table lookup by the registered state only.
  always_comb begin
    w_digit = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (r_state == STATE_W'(i)) begin
        w_digit = r_table[i];
      end
    end
  end

  assign current_state = r_state;
  assign digit         = w_digit;
  assign wrap          = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_moore_digit_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_moore_digit_sequencer
//  Description : Self-checking bench for moore_digit_sequencer. Drives an
//                edge-stepped and a level-stepped instance with identical
//                inputs and compares both against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_moore_digit_sequencer;

  localparam int c_n = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       step = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] prescale = 8'd0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [3:0] wr_data = 4'd0;

  logic [3:0] state_e, digit_e, state_l, digit_l;
  logic       wrap_e, wrap_l;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: index 0 = edge-stepped instance, 1 = level-stepped.
  int m_st   [2];
  int m_cnt  [2];
  int m_sq   [2];
  int m_wrap [2];
  int m_tbl  [c_n];

  moore_digit_sequencer #(.EDGE_STEP(1)) dut_edge (
    .clock(clock), .reset(reset), .clear(clear), .step(step), .dir(dir),
    .mode(mode), .prescale(prescale), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .current_state(state_e), .digit(digit_e), .wrap(wrap_e)
  );

  moore_digit_sequencer #(.EDGE_STEP(0)) dut_lvl (
    .clock(clock), .reset(reset), .clear(clear), .step(step), .dir(dir),
    .mode(mode), .prescale(prescale), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .current_state(state_l), .digit(digit_l), .wrap(wrap_l)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_sq[k] = 0; m_wrap[k] = 0;
    end
    for (int i = 0; i < c_n; i++) m_tbl[i] = i % 16;
  endtask

  // One clock edge of the sequencer rules, applied to the current inputs.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      bit adv;
      adv = 1'b0;
      if (mode == 2'b00) begin
        adv = (k == 0) ? (step && (m_sq[k] == 0)) : step;
      end else if (mode == 2'b01) begin
        adv = (m_cnt[k] == int'(prescale));
        m_cnt[k] = adv ? 0 : (m_cnt[k] + 1) % 256;
      end else begin
        m_cnt[k] = 0;
      end
      if (mode != 2'b01) m_cnt[k] = 0;
      m_wrap[k] = 0;
      if (adv) begin
        if (!dir) begin
          m_wrap[k] = (m_st[k] == c_n - 1);
          m_st[k]   = (m_st[k] + 1) % c_n;
        end else begin
          m_wrap[k] = (m_st[k] == 0);
          m_st[k]   = (m_st[k] + c_n - 1) % c_n;
        end
      end
      if (clear) begin
        m_st[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0;
      end
      m_sq[k] = step;
    end
    if (wr_en && (int'(wr_addr) < c_n)) m_tbl[wr_addr] = int'(wr_data);
  endtask

  task automatic check_all();
    check_eq("edge_state", state_e, m_st[0]);
    check_eq("edge_digit", digit_e, m_tbl[m_st[0]]);
    check_eq("edge_wrap",  wrap_e,  m_wrap[0]);
    check_eq("lvl_state",  state_l, m_st[1]);
    check_eq("lvl_digit",  digit_l, m_tbl[m_st[1]]);
    check_eq("lvl_wrap",   wrap_l,  m_wrap[1]);
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
    check_all();
  endtask

  task automatic pulse();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    clear = 0; step = 0; dir = 0; mode = 2'b00; prescale = 0; wr_en = 0;
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    check_eq("reset_state", state_e, 0);
    check_eq("reset_digit", digit_e, 0);
    check_eq("reset_wrap",  wrap_e,  0);
    reset = 1'b0;

    // Eight manual up pulses walk the default table and wrap on the last.
    for (int i = 0; i < 8; i++) begin
      step = 1'b1;
      tick();
      check_eq("seq_digit", digit_e, (i + 1) % 8);
      check_eq("seq_wrap",  wrap_e,  (i == 7) ? 1 : 0);
      step = 1'b0;
      tick();
    end

    // Step held high: one advance when edge-stepped, five when level-stepped.
    do_reset();
    step = 1'b1;
    repeat (5) tick();
    step = 1'b0;
    check_eq("held_edge_state", state_e, 1);
    check_eq("held_lvl_state",  state_l, 5);

    // Auto mode, period 4: two advances in eight cycles.
    do_reset();
    mode = 2'b01; prescale = 8'd3;
    repeat (8) tick();
    check_eq("auto_p3_state", state_e, 2);

    // Auto mode, every cycle, downward: wraps to 7 then 6, 5.
    do_reset();
    mode = 2'b01; prescale = 8'd0; dir = 1'b1;
    tick();
    check_eq("down_state7", state_e, 7);
    check_eq("down_wrap",   wrap_e,  1);
    tick();
    check_eq("down_state6", state_e, 6);
    tick();
    check_eq("down_state5", state_e, 5);

    // Table write then two steps shows the written entry.
    do_reset();
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'hA;
    tick();
    wr_en = 1'b0;
    pulse();
    pulse();
    check_eq("wr_state", state_e, 2);
    check_eq("wr_digit", digit_e, 4'hA);

    // Out-of-range write leaves the whole table at its defaults.
    do_reset();
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 4'hF;
    tick();
    wr_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      pulse();
      check_eq("oor_digit", digit_e, i % 8);
    end

    // Clear beats a simultaneous step edge.
    do_reset();
    repeat (5) pulse();
    check_eq("pre_clear_state", state_e, 5);
    clear = 1'b1; step = 1'b1;
    tick();
    check_eq("clear_state", state_e, 0);
    check_eq("clear_wrap",  wrap_e,  0);
    clear = 1'b0; step = 1'b0;
    tick();

    // Async reset during auto run restores state and table before any edge.
    do_reset();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'h5;
    tick();
    wr_en = 1'b0;
    mode = 2'b01; prescale = 8'd0;
    repeat (3) tick();
    check_eq("auto_run_state", state_e, 3);
    reset = 1'b1;
    #1;
    check_eq("async_rst_state", state_e, 0);
    check_eq("async_rst_digit", digit_e, 0);
    model_reset();
    mode = 2'b00;
    #1;
    reset = 1'b0;
    tick();
    check_eq("post_rst_digit", digit_e, 0);

    // Randomized run against the model.
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      int r;
      r = $urandom_range(0, 9);
      mode  = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      step  = 1'($urandom % 2);
      dir   = 1'($urandom % 2);
      clear = ($urandom % 40) == 0;
      if ($urandom % 30 == 0) prescale = 8'($urandom_range(0, 4));
      if ($urandom % 300 == 0) prescale = 8'($urandom);
      wr_en   = ($urandom % 8) == 0;
      wr_addr = 4'($urandom);
      wr_data = 4'($urandom);
      if ($urandom % 500 == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("rand_async_state", state_e, 0);
        check_eq("rand_async_digit", digit_e, 0);
        reset = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/moore_digit_sequencer.md
Name: moore_digit_sequencer

Overview:
- Parametrised Moore digit sequencer: an N-state ring counter. Each state indexes a writable digit table, and the addressed digit drives the display/ID output.
- Adds the following:
  - configurable state count and digit width
  - up/down direction
  - edge-qualified or level stepping
  - free-running auto mode with prescaler
  - runtime table load
  - synchronous clear
  - wrap strobe
- Sits between the input debouncer / control path and the 7-segment decoder.

Parameters:
- NUM_STATES, 8, number of states in the ring (2..16).
- STATE_W, 4, width of the state index; must satisfy 2^STATE_W >= NUM_STATES.
- DIGIT_W, 4, width of each table entry and of the digit output.
- PRESCALE_W, 8, width of the auto-mode prescaler.
- EDGE_STEP, 1, 1 = advance on a 0->1 edge of step; 0 = advance every cycle step is high.

Ports:
- clock, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high.
- clear, input, 1, synchronous return to state 0; does not alter the table.
- step, input, 1, manual advance request.
- dir, input, 1, 0 = up (i -> i+1), 1 = down (i -> i-1).
- mode, input, 2, 00 manual, 01 auto, 10 hold, 11 reserved (behaves as hold).
- prescale, input, PRESCALE_W, auto-mode period minus 1.
- wr_en, input, 1, table write strobe.
- wr_addr, input, STATE_W, table entry to write.
- wr_data, input, DIGIT_W, value to write.
- current_state, output, STATE_W, registered state index.
- digit, output, DIGIT_W, table[current_state]; Moore output, no dependence on inputs.
- wrap, output, 1, registered one-cycle pulse when the state wraps.

Behaviour:
- Reset (async) values:
  - current_state = 0
  - wrap = 0
  - prescaler count = 0
  - step edge register = 0
  - table[i] = i mod 2^DIGIT_W
  - digit therefore = 0
- Advance, up direction: next = (state == NUM_STATES-1) ? 0 : state+1.
- Advance, down direction: next = (state == 0) ? NUM_STATES-1 : state-1.
- Wrap: wrap = 1 in the same cycle current_state takes the wrapped value; 0 otherwise.
- Manual mode, EDGE_STEP=1: advance once per cycle where step=1 and step_q=0.
  - step_q = step registered every cycle in all modes, so no phantom edge occurs on entering manual.
- Manual mode, EDGE_STEP=0: advance on every clock with step=1.
- Auto mode:
  - step is ignored.
  - The counter increments each cycle.
  - When count == prescale: advance and set count to 0.
  - prescale=0 advances every cycle.
  - A prescale change mid-count uses the new value; if count > prescale, the advance fires at the next compare-equal after counter wrap at 2^PRESCALE_W.
- Hold/reserved mode: state frozen; prescaler count forced to 0.
- Leaving auto mode: prescaler count = 0.
- clear:
  - Sets state = 0, prescaler = 0, wrap = 0.
  - Has priority over any advance in the same cycle.
  - Does not generate wrap.
- Table write:
  - table[wr_addr] <= wr_data on the clock edge.
  - wr_addr >= NUM_STATES is ignored.
  - Independent of stepping; a write and an advance in the same cycle both take effect.
  - digit reflects a written entry from the cycle after the write edge.
- Output path: digit is a combinational read of the table registers by current_state only.
- Out-of-range state (unreachable): next state = 0.
- Reset mid-operation: all state returns to reset values immediately; any table contents written at runtime are lost.

Test Plan:
- Reset, then 8 single-cycle step pulses, EDGE_STEP=1, mode=00, dir=0.
  -> digit sequence 1,2,3,4,5,6,7,0.
  -> wrap high exactly on the 8th advance.
- step held high 5 cycles, EDGE_STEP=1 -> exactly one advance (state 0->1).
- Same stimulus with EDGE_STEP=0 -> state reaches 5.
- mode=01, prescale=3 from state 0 -> advances every 4th cycle; state 2 after 8 cycles.
- mode=01, prescale=0, dir=1 from state 0 -> state 7 next cycle with wrap=1, then 6, 5.
- wr_en with wr_addr=2, wr_data=4'hA, then step twice -> digit=4'hA at state 2.
- Write to wr_addr=9 -> table unchanged.
- clear asserted with a step edge in the same cycle at state 5 -> state 0, wrap=0.
- Async reset pulse mid auto-run -> current_state=0 and digit=0 before the next clock edge; table restored to defaults.
